// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared serializer state encoding and index-width helpers
package nn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // An index register is never narrower than one bit.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/layer_serializer_if.sv
// rtl/layer_serializer_if.sv - upstream parallel vector and downstream element stream
interface layer_serializer_if #(
  parameter int NN = 10,
  parameter int DW = 16
);

  logic [NN-1:0]    i_valid;
  logic [NN*DW-1:0] i_data;
  logic             o_x_valid;
  logic [DW-1:0]    o_x_data;

  modport master (
    output i_valid,
    output i_data,
    input  o_x_valid,
    input  o_x_data
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_x_valid,
    output o_x_data
  );

endinterface

// File: rtl/argmax_tracker.sv
// rtl/argmax_tracker.sv - running signed maximum and index over one streamed vector
module argmax_tracker #(
  parameter int DW = 16,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          el_valid,
  input  logic [DW-1:0] el_data,
  input  logic [IW-1:0] el_index,
  input  logic          el_first,
  input  logic          el_last,
  output logic [DW-1:0] o_max,
  output logic [IW-1:0] o_argmax,
  output logic          o_done
);

  logic [DW-1:0] run_max_q;
  logic [IW-1:0] run_idx_q;
  logic          take;
  logic [DW-1:0] cand_max;
  logic [IW-1:0] cand_idx;

  // Strict greater-than so a tie keeps the earlier (lower) index.
  always_comb begin
    take     = el_first || ($signed(el_data) > $signed(run_max_q));
    cand_max = take ? el_data : run_max_q;
    cand_idx = take ? el_index : run_idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_max_q <= '0;
      run_idx_q <= '0;
      o_max     <= '0;
      o_argmax  <= '0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (el_valid) begin
        run_max_q <= cand_max;
        run_idx_q <= cand_idx;
        if (el_last) begin
          o_max    <= cand_max;
          o_argmax <= cand_idx;
          o_done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - parallel layer result to x_valid/x_in stream, optional argmax under SER_ARGMAX_EN
module layer_serializer
  import nn_pkg::*;
#(
  parameter int NN        = 10,
  parameter int dataWidth = 16,
  localparam int IW       = idx_width(NN)
) (
  input  logic                 clk,
  input  logic                 rst,
  layer_serializer_if.slave    bus,
  output logic                 o_busy,
  output logic                 o_overflow,
  output logic [IW-1:0]        o_argmax,
  output logic [dataWidth-1:0] o_max,
  output logic                 o_argmax_valid
);

  ser_state_t                  state_q, state_d;
  logic [NN*dataWidth-1:0]     shbuf_q;
  logic [NN*dataWidth-1:0]     pend_q;
  logic [IW-1:0]               idx_q;
  logic                        pend_full_q;
  logic                        overflow_q;
  logic                        capture;
  logic                        last;
  logic                        x_valid;
  logic [dataWidth-1:0]        x_data;

  assign capture = &bus.i_valid;
  assign last    = (state_q == SHIFT) && (idx_q == IW'(NN - 1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (capture) state_d = SHIFT;
      SHIFT: if (last && !pend_full_q && !capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift buffer, holding buffer and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shbuf_q     <= '0;
      pend_q      <= '0;
      idx_q       <= '0;
      pend_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (capture) begin
            shbuf_q <= bus.i_data;
            idx_q   <= '0;
          end
        end
        SHIFT: begin
          if (last) begin
            idx_q <= '0;
            if (pend_full_q) begin
              shbuf_q <= pend_q;
              if (capture) pend_q      <= bus.i_data;
              else         pend_full_q <= 1'b0;
            end else if (capture) begin
              shbuf_q <= bus.i_data;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
            if (capture) begin
              if (!pend_full_q) begin
                pend_q      <= bus.i_data;
                pend_full_q <= 1'b1;
              end else begin
                overflow_q <= 1'b1;
              end
            end
          end
        end
        default: idx_q <= '0;
      endcase
    end
  end

  always_comb begin
    x_valid        = (state_q == SHIFT);
    x_data         = x_valid ? shbuf_q[int'(idx_q)*dataWidth +: dataWidth] : '0;
    bus.o_x_valid  = x_valid;
    bus.o_x_data   = x_data;
    o_busy         = x_valid | pend_full_q;
    o_overflow     = overflow_q;
  end

`ifdef SER_ARGMAX_EN
  argmax_tracker #(
    .DW (dataWidth),
    .IW (IW)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .el_valid (x_valid),
    .el_data  (x_data),
    .el_index (idx_q),
    .el_first (idx_q == '0),
    .el_last  (last),
    .o_max    (o_max),
    .o_argmax (o_argmax),
    .o_done   (o_argmax_valid)
  );
`else
  assign o_argmax       = '0;
  assign o_max          = '0;
  assign o_argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - randomized and directed check of layer_serializer against a queue model
module tb_layer_serializer;

  localparam int NN = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic          o_busy, o_overflow, o_argmax_valid;
  logic [IW-1:0] o_argmax;
  logic [DW-1:0] o_max;

  always #5 clk = ~clk;

  layer_serializer_if #(.NN(NN), .DW(DW)) bus ();

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .o_busy         (o_busy),
    .o_overflow     (o_overflow),
    .o_argmax       (o_argmax),
    .o_max          (o_max),
    .o_argmax_valid (o_argmax_valid)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding elements in emission order; capacity is the vector in flight plus one.
  typedef struct {
    logic [DW-1:0] d;
    bit            last;
    logic [IW-1:0] ai;
    logic [DW-1:0] am;
  } el_t;

  el_t           mq[$];
  bit            m_ovf = 1'b0;
  bit            m_amv = 1'b0;
  logic [IW-1:0] m_ami = '0;
  logic [DW-1:0] m_amx = '0;

  function automatic void push_vec(input logic [NN*DW-1:0] v);
    int   best;
    el_t  e;
    best = 0;
    for (int k = 1; k < NN; k++)
      if ($signed(v[k*DW +: DW]) > $signed(v[best*DW +: DW])) best = k;
    for (int k = 0; k < NN; k++) begin
      e.d    = v[k*DW +: DW];
      e.last = (k == NN - 1);
      e.ai   = IW'(best);
      e.am   = v[best*DW +: DW];
      mq.push_back(e);
    end
  endfunction

  always @(posedge clk) begin
    el_t e;
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_amv = 1'b0;
      m_ami = '0;
      m_amx = '0;
    end else begin
      m_amv = 1'b0;
      if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.last) begin
          m_amv = 1'b1;
          m_ami = e.ai;
          m_amx = e.am;
        end
      end
      if (&bus.i_valid) begin
        if (mq.size() <= NN) push_vec(bus.i_data);
        else                 m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("x_valid", bus.o_x_valid, (mq.size() > 0));
      chk("x_data", bus.o_x_data, (mq.size() > 0) ? mq[0].d : '0);
      chk("busy", o_busy, (mq.size() > 0));
      chk("overflow", o_overflow, m_ovf);
`ifdef SER_ARGMAX_EN
      chk("argmax_valid", o_argmax_valid, m_amv);
      chk("argmax", o_argmax, m_ami);
      chk("max", o_max, m_amx);
`else
      chk("argmax_valid_tied", o_argmax_valid, 1'b0);
      chk("argmax_tied", o_argmax, '0);
      chk("max_tied", o_max, '0);
`endif
    end
  end

  // Directed windows: captures scheduled by negedge index, outputs recorded per negedge.
  int               cap_n[4];
  logic [NN-1:0]    cap_m[4];
  logic [NN*DW-1:0] cap_v[4];
  logic             rec_v[48], rec_b[48], rec_o[48], rec_amv[48];
  logic [DW-1:0]    rec_d[48], rec_amx[48];
  logic [IW-1:0]    rec_ami[48];

  task automatic window(input int ncap, input int n_total, input int rst_at);
    for (int n = 0; n < n_total; n++) begin
      @(negedge clk);
      rec_v[n]   = bus.o_x_valid;
      rec_d[n]   = bus.o_x_data;
      rec_b[n]   = o_busy;
      rec_o[n]   = o_overflow;
      rec_amv[n] = o_argmax_valid;
      rec_ami[n] = o_argmax;
      rec_amx[n] = o_max;
      bus.i_valid = '0;
      bus.i_data  = '0;
      for (int j = 0; j < ncap; j++)
        if (cap_n[j] == n) begin
          bus.i_valid = cap_m[j];
          bus.i_data  = cap_v[j];
        end
      if (n == rst_at)          rst = 1'b0;
      else if (n == rst_at + 1) rst = 1'b1;
    end
  endtask

  function automatic logic [NN*DW-1:0] mkvec(input int base, input int step);
    logic [NN*DW-1:0] v;
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = DW'(base + step * k);
    return v;
  endfunction

  initial begin
    int pulses;
    logic [DW-1:0] am_vals[NN];
    bus.i_valid = '0;
    bus.i_data  = '0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_x_valid", bus.o_x_valid, 1'b0);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_overflow", o_overflow, 1'b0);
    rst = 1'b1;

    cap_n[0] = 0; cap_m[0] = '1; cap_v[0] = mkvec(10, 10);
    window(1, 14, -10);
    for (int k = 0; k < NN; k++) chk("single_data", rec_d[k+1], 10 * (k + 1));
    chk("single_first_valid", rec_v[1], 1'b1);
    chk("single_end_valid", rec_v[11], 1'b0);
    chk("single_end_busy", rec_b[11], 1'b0);

    cap_n[0] = 0; cap_m[0] = 10'h3FE; cap_v[0] = mkvec(5, 1);
    window(1, 4, -10);
    for (int n = 1; n < 4; n++) chk("partial_busy", {rec_v[n], rec_b[n]}, 2'b00);

    cap_n[0] = 0; cap_m[0] = '1; cap_v[0] = mkvec(10, 10);
    cap_n[1] = 3; cap_m[1] = '1; cap_v[1] = mkvec(1, 1);
    window(2, 24, -10);
    for (int k = 0; k < 2 * NN; k++) chk("dbl_valid", rec_v[k+1], 1'b1);
    chk("dbl_elem9", rec_d[10], 16'd100);
    chk("dbl_elem10", rec_d[11], 16'd1);
    chk("dbl_elem19", rec_d[20], 16'd10);
    chk("dbl_end_valid", rec_v[21], 1'b0);
    chk("dbl_overflow", rec_o[22], 1'b0);

    cap_n[0] = 0; cap_m[0] = '1; cap_v[0] = mkvec(100, 1);
    cap_n[1] = 2; cap_m[1] = '1; cap_v[1] = mkvec(200, 1);
    cap_n[2] = 4; cap_m[2] = '1; cap_v[2] = mkvec(300, 1);
    window(3, 26, -10);
    chk("ovf_a0", rec_d[1], 16'd100);
    chk("ovf_b0", rec_d[11], 16'd200);
    chk("ovf_b9", rec_d[20], 16'd209);
    chk("ovf_dropped", rec_v[21], 1'b0);
    chk("ovf_sticky", rec_o[25], 1'b1);

    cap_n[0] = 0; cap_m[0] = '1; cap_v[0] = mkvec(50, 2);
    window(1, 9, 5);
    chk("rst_elem4", rec_d[5], 16'd58);
    chk("rst_outputs", {rec_v[6], rec_b[6], rec_o[6], rec_d[6]}, '0);
    cap_n[0] = 0; cap_m[0] = '1; cap_v[0] = mkvec(3, 5);
    window(1, 4, -10);
    chk("rst_fresh_elem0", rec_d[1], 16'd3);

    am_vals = '{16'hFFFB, 16'd7, 16'd3, 16'd7, 16'h8000, 16'd0, 16'd1, 16'd2, 16'hFFFF, 16'd6};
    for (int k = 0; k < NN; k++) cap_v[0][k*DW +: DW] = am_vals[k];
    cap_n[0] = 0; cap_m[0] = '1;
    window(1, 14, -10);
    pulses = 0;
    for (int n = 0; n < 14; n++) pulses += int'(rec_amv[n]);
`ifdef SER_ARGMAX_EN
    chk("am_pulse", rec_amv[11], 1'b1);
    chk("am_pulses", pulses, 1);
    chk("am_index", rec_ami[11], 4'd1);
    chk("am_max", rec_amx[11], 16'd7);
    chk("am_hold", rec_amx[13], 16'd7);
`else
    chk("am_pulses_tied", pulses, 0);
`endif

    repeat (3000) begin
      @(negedge clk);
      bus.i_data = '0;
      for (int k = 0; k < NN; k++) bus.i_data[k*DW +: DW] = DW'($urandom);
      case ($urandom_range(0, 15))
        0, 1, 2: bus.i_valid = '1;
        3, 4:    bus.i_valid = NN'($urandom) & ~(NN'(1) << $urandom_range(0, NN - 1));
        default: bus.i_valid = '0;
      endcase
      rst = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    bus.i_valid = '0;
    rst = 1'b1;
    repeat (25) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Parallel-to-serial bridge between two fully-connected layers. It captures the `NN` activations that one layer produces in parallel and replays them one per cycle as the `x_valid`/`x_in` stream the next layer's neurons consume. It has a one-vector holding buffer so a new layer result can arrive while the previous one is still streaming. It optionally tracks the argmax of the streamed vector for use after the final layer.

## Interface
Parameters:
- `NN`, 10 — number of neurons in the upstream layer (elements per vector), ≥2
- `dataWidth`, 16 — activation width, two's complement

Ports:
- `clk`  in  1  — single clock, rising edge
- `rst`  in  1  — synchronous, active-low reset
- `i_valid`  in  NN  — per-neuron output valid from the upstream layer
- `i_data`  in  NN*dataWidth  — upstream activations; element k is `i_data[k*dataWidth +: dataWidth]`
- `o_x_valid`  out  1  — element valid toward the next layer's `x_valid`
- `o_x_data`  out  dataWidth  — element toward the next layer's `x_in`
- `o_busy`  out  1  — streaming, or holding buffer occupied
- `o_overflow`  out  1  — sticky: a vector was dropped
- `o_argmax`  out  clog2(NN)  — index of the maximum element (`SER_ARGMAX_EN` only)
- `o_max`  out  dataWidth  — value of the maximum element (`SER_ARGMAX_EN` only)
- `o_argmax_valid`  out  1  — one-cycle pulse, argmax result ready (`SER_ARGMAX_EN` only)

## Operation
- **Capture event:** `&i_valid == 1` in a sampled cycle. Partial `i_valid` is ignored; no partial vectors are ever stored.
- **Storage:**
  - Shift buffer: NN × dataWidth, plus index counter `idx` (clog2(NN) bits).
  - Holding buffer `pend`, plus flag `pend_full`.
- **FSM `IDLE`:**
  - On capture, load the shift buffer, set `idx=0`, and go to `SHIFT`.
- **FSM `SHIFT`:**
  - Each cycle drive `o_x_valid=1` and `o_x_data=element[idx]`, then increment `idx`.
  - Element 0 (lowest slice) is sent first.
- **End of vector (`idx==NN-1` emitted):**
  - If `pend_full`: move `pend` into the shift buffer, set `idx=0`, stay in `SHIFT`, and clear `pend_full`, unless a capture occurs in the same cycle. In that case the new vector goes into `pend` and `pend_full` stays set.
  - Else, on a capture in the same cycle: load the new vector directly into the shift buffer and stay in `SHIFT`.
  - Otherwise go to `IDLE`.
- **Capture in `SHIFT` (not the last cycle):**
  - If `pend` is empty, store the vector into `pend` and set `pend_full`.
  - If `pend` is full, drop the new vector and set `o_overflow`. The existing `pend` content is kept.
- **Status outputs:**
  - `o_busy = (state==SHIFT) | pend_full`.
  - `o_overflow` is cleared only by reset.
- **Reset (`rst==0` at an edge):**
  - State `IDLE`, `idx=0`, `pend_full=0`.
  - All outputs 0: `o_x_valid`, `o_x_data`, `o_busy`, `o_overflow`, `o_argmax`, `o_max`, `o_argmax_valid`.
  - Reset mid-stream aborts the vector immediately; no further elements are emitted.

## Timing
- Capture sampled at edge T; element 0 is valid in the cycle after edge T, and element k in cycle T+1+k. Latency is 1 cycle.
- One vector occupies exactly NN consecutive `o_x_valid` cycles.
- Back-to-back vectors produce no bubble.
- Sustained throughput is one vector per NN cycles. Faster capture rates overflow.
- Outputs are registered; no combinational path from `i_*` to `o_*`.
- `o_x_data` is 0 when `o_x_valid==0`.

## Configuration
- Macro: `SER_ARGMAX_EN`.
- **Defined:**
  - A running signed maximum and its index are tracked over the emitted elements. A tie keeps the lower index.
  - `o_argmax_valid` pulses for 1 cycle, on the cycle after element NN-1 is emitted.
  - `o_argmax` and `o_max` update on that pulse and hold until the next pulse.
  - The tracker resets its running maximum at each element 0.
- **Undefined:** the argmax ports still exist, tied to 0. No tracker logic is generated.

## Structure
- Shared package `nn_pkg`:
  - serializer state encoding (`IDLE`, `SHIFT`)
  - clog2 helper function
  - index-width constant derivation
- Sub-module `argmax_tracker`, instantiated under `SER_ARGMAX_EN`:
  - inputs: element valid, data, index, first-element flag, last-element flag
  - outputs: max, argmax, done pulse

## Test plan
- **Single vector, NN=10:** elements 0..9 = 10,20,…,100, all `i_valid` high for 1 cycle → `o_x_valid` high for 10 cycles starting the next cycle, data 10..100 in order, then `IDLE` and `o_busy=0`.
- **Partial valid:** `i_valid=10'h3FE` → no output, no state change, `o_busy` stays 0.
- **Double buffer:** second vector (values 1..10) captured at stream cycle 3 → 20 contiguous valid cycles: 10..100, then 1..10; `o_overflow=0`.
- **Overflow:** three captures within the first 5 stream cycles → first two vectors emitted back-to-back, third dropped, `o_overflow=1` until reset.
- **Reset mid-stream:** `rst=0` after element 4 → `o_x_valid=0` the next cycle, all outputs 0, and a fresh capture afterward streams from element 0.
- **Argmax (`SER_ARGMAX_EN`):** elements -5, 7, 3, 7, -32768, 0, … → `o_argmax=1`, `o_max=7`, and `o_argmax_valid` pulses once, the cycle after the last element.
